sparse_chunk_packer: RTL

//  Write-side counterpart of the sparse read-address path. Takes dense IFM beats of LANES elements and emits one

---
 rtl/sparse_chunk_packer_if.sv | 38 +++
 rtl/sparse_chunk_packer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sparse_chunk_packer_if.sv
// Bundle of the dense-beat input, sparsemap write port and packed data
// write port of the sparse chunk packer.
interface sparse_chunk_packer_if #(
  parameter int LANES     = 32,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
);
  localparam int AW = $clog2(MEM_DEPTH) + 1;
  localparam int BW = $clog2(MEM_DEPTH / LANES);

  logic                    chunk_start_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [LANES*DATA_W-1:0] in_data_i;
  logic                    smap_we_o;
  logic [BW-1:0]           smap_addr_o;
  logic [LANES-1:0]        smap_data_o;
  logic                    dat_we_o;
  logic [AW-1:0]           dat_addr_o;
  logic [DATA_W-1:0]       dat_data_o;
  logic                    chunk_done_o;
  logic [AW-1:0]           nz_count_o;
  logic                    busy_o;

  // Producer side: drives beats and chunk starts, observes the writes.
  modport master (
    output chunk_start_i, in_valid_i, in_data_i,
    input  in_ready_o, smap_we_o, smap_addr_o, smap_data_o,
    input  dat_we_o, dat_addr_o, dat_data_o, chunk_done_o, nz_count_o, busy_o
  );

  // Packer side.
  modport slave (
    input  chunk_start_i, in_valid_i, in_data_i,
    output in_ready_o, smap_we_o, smap_addr_o, smap_data_o,
    output dat_we_o, dat_addr_o, dat_data_o, chunk_done_o, nz_count_o, busy_o
  );
endinterface

// File: rtl/sparse_chunk_packer.sv
// Sparse chunk packer: turns dense IFM beats into one sparsemap word per beat
// and packs the nonzero elements contiguously (lane order, then beat order)
// into the chunk data memory, one element per cycle, from address 0.
module sparse_chunk_packer #(
  parameter int LANES     = 32,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input logic                 clk_i,
  input logic                 rst_i,
  sparse_chunk_packer_if.slave bus
);
  localparam int CHUNK_BEATS = MEM_DEPTH / LANES;
  localparam int AW = $clog2(MEM_DEPTH) + 1;
  localparam int BW = $clog2(CHUNK_BEATS);
  localparam int IW = $clog2(LANES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(CHUNK_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SER    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [LANES*DATA_W-1:0] beat_q, beat_d;
  logic                    smap_we_q, smap_we_d;
  logic [BW-1:0]           smap_addr_q, smap_addr_d;
  logic [LANES-1:0]        smap_data_q, smap_data_d;
  logic                    dat_we_q, dat_we_d;
  logic [AW-1:0]           dat_addr_q, dat_addr_d;
  logic [DATA_W-1:0]       dat_data_q, dat_data_d;
  logic                    chunk_done_q, chunk_done_d;
  logic [AW-1:0]           nz_count_q, nz_count_d;
  logic                    busy_q, busy_d;

  logic                    in_ready_s;
  logic                    accept_s;
  logic [LANES-1:0]        in_mask_s;
  logic [IW-1:0]           ser_idx_s;
  logic [LANES-1:0]        mask_rest_s;
  logic                    last_beat_s;

  // Per-lane nonzero flags of a dense beat.
  function automatic logic [LANES-1:0] nz_mask(input logic [LANES*DATA_W-1:0] beat);
    logic [LANES-1:0] m;
    for (int j = 0; j < LANES; j++) begin
      m[j] = |beat[j*DATA_W +: DATA_W];
    end
    return m;
  endfunction

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [IW-1:0] lowest_idx(input logic [LANES-1:0] m);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = IW'(i);
      end
    end
    return idx;
  endfunction

  // Handshake qualifiers and serialiser helpers; a chunk start always wins over a beat.
  always_comb begin
    in_ready_s  = (state_q == ACCEPT) && !bus.chunk_start_i;
    accept_s    = in_ready_s && bus.in_valid_i;
    in_mask_s   = nz_mask(bus.in_data_i);
    ser_idx_s   = lowest_idx(mask_q);
    mask_rest_s = mask_q & (mask_q - {{(LANES-1){1'b0}}, 1'b1});
    last_beat_s = (beat_cnt_q == LAST_BEAT);
  end

  // Next-state and next-output computation; write strobes and payloads default low/zero.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    beat_cnt_d   = beat_cnt_q;
    mask_d       = mask_q;
    beat_d       = beat_q;
    smap_we_d    = 1'b0;
    smap_addr_d  = {BW{1'b0}};
    smap_data_d  = {LANES{1'b0}};
    dat_we_d     = 1'b0;
    dat_addr_d   = {AW{1'b0}};
    dat_data_d   = {DATA_W{1'b0}};
    chunk_done_d = 1'b0;
    nz_count_d   = nz_count_q;
    if (bus.chunk_start_i) begin
      // Start or abort: drop everything in flight and begin a fresh chunk.
      state_d    = ACCEPT;
      wr_addr_d  = {AW{1'b0}};
      beat_cnt_d = {BW{1'b0}};
      mask_d     = {LANES{1'b0}};
      beat_d     = {(LANES*DATA_W){1'b0}};
      nz_count_d = {AW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACCEPT: begin
          if (accept_s) begin
            beat_d      = bus.in_data_i;
            mask_d      = in_mask_s;
            smap_we_d   = 1'b1;
            smap_addr_d = beat_cnt_q;
            smap_data_d = in_mask_s;
            if (in_mask_s != {LANES{1'b0}}) begin
              state_d = SER;
            end else begin
              // All-zero beat is finished at acceptance.
              beat_cnt_d = beat_cnt_q + {{(BW-1){1'b0}}, 1'b1};
              state_d    = last_beat_s ? DONE : ACCEPT;
            end
          end else begin
            state_d = ACCEPT;
          end
        end
        SER: begin
          dat_we_d   = 1'b1;
          dat_addr_d = wr_addr_q;
          dat_data_d = beat_q[ser_idx_s*DATA_W +: DATA_W];
          mask_d     = mask_rest_s;
          wr_addr_d  = wr_addr_q + {{(AW-1){1'b0}}, 1'b1};
          if (mask_rest_s == {LANES{1'b0}}) begin
            beat_cnt_d = beat_cnt_q + {{(BW-1){1'b0}}, 1'b1};
            state_d    = last_beat_s ? DONE : ACCEPT;
          end else begin
            state_d = SER;
          end
        end
        DONE: begin
          chunk_done_d = 1'b1;
          nz_count_d   = wr_addr_q;
          state_d      = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, cleared immediately on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wr_addr_q    <= {AW{1'b0}};
      beat_cnt_q   <= {BW{1'b0}};
      mask_q       <= {LANES{1'b0}};
      beat_q       <= {(LANES*DATA_W){1'b0}};
      smap_we_q    <= 1'b0;
      smap_addr_q  <= {BW{1'b0}};
      smap_data_q  <= {LANES{1'b0}};
      dat_we_q     <= 1'b0;
      dat_addr_q   <= {AW{1'b0}};
      dat_data_q   <= {DATA_W{1'b0}};
      chunk_done_q <= 1'b0;
      nz_count_q   <= {AW{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      mask_q       <= mask_d;
      beat_q       <= beat_d;
      smap_we_q    <= smap_we_d;
      smap_addr_q  <= smap_addr_d;
      smap_data_q  <= smap_data_d;
      dat_we_q     <= dat_we_d;
      dat_addr_q   <= dat_addr_d;
      dat_data_q   <= dat_data_d;
      chunk_done_q <= chunk_done_d;
      nz_count_q   <= nz_count_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready_o   = in_ready_s;
  assign bus.smap_we_o    = smap_we_q;
  assign bus.smap_addr_o  = smap_addr_q;
  assign bus.smap_data_o  = smap_data_q;
  assign bus.dat_we_o     = dat_we_q;
  assign bus.dat_addr_o   = dat_addr_q;
  assign bus.dat_data_o   = dat_data_q;
  assign bus.chunk_done_o = chunk_done_q;
  assign bus.nz_count_o   = nz_count_q;
  assign bus.busy_o       = busy_q;
endmodule
